// File: rtl/pc_unit_pkg.sv
// Shared select encodings and default sizing for the program-counter unit.
package pc_unit_pkg;

  typedef enum logic [2:0] {
    PcInc    = 3'd0,
    PcSysbus = 3'd1,
    PcAluOut = 3'd2,
    PcLr     = 3'd3,
    PcRas    = 3'd4
  } pc_select_t;

  typedef enum logic {
    LrSys = 1'b0,
    LrPc  = 1'b1
  } Lr_select_t;

  localparam int DEF_WIDTH        = 16;
  localparam int DEF_RAS_DEPTH    = 4;
  localparam int DEF_RESET_VECTOR = 0;
  localparam int DEF_INC_STEP     = 1;

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack with saturating count and sticky overflow/underflow flags.
module ras_stack
  import pc_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_RAS_DEPTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Push,
  input  logic             Pop,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Top,
  output logic             Full,
  output logic             Empty,
  output logic             Ovf,
  output logic             Unf,
  input  logic             FlagClr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr, ptr_next, wr_idx;
  logic [CW-1:0]    count, count_next;
  logic             wr_en, ovf_evt, unf_evt;

  assign Full  = (count == CW'(DEPTH));
  assign Empty = (count == '0);
  assign Top   = mem[ptr];

  always_comb begin
    ptr_next   = ptr;
    count_next = count;
    wr_en      = 1'b0;
    wr_idx     = ptr + PW'(1);
    ovf_evt    = 1'b0;
    unf_evt    = 1'b0;
    if (Push && Pop) begin
      // Replace the top in place; on an empty stack there is no top, so it becomes a push.
      wr_en = 1'b1;
      if (Empty) begin
        ptr_next   = ptr + PW'(1);
        count_next = CW'(1);
        unf_evt    = 1'b1;
      end else begin
        wr_idx = ptr;
      end
    end else if (Push) begin
      wr_en    = 1'b1;
      ptr_next = ptr + PW'(1);
      if (Full) ovf_evt = 1'b1;
      else      count_next = count + CW'(1);
    end else if (Pop) begin
      if (Empty) begin
        unf_evt = 1'b1;
      end else begin
        ptr_next   = ptr - PW'(1);
        count_next = count - CW'(1);
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ptr   <= '0;
      count <= '0;
      Ovf   <= 1'b0;
      Unf   <= 1'b0;
    end else begin
      ptr   <= ptr_next;
      count <= count_next;
      Ovf   <= (Ovf & ~FlagClr) | ovf_evt;
      Unf   <= (Unf & ~FlagClr) | unf_evt;
    end
  end

  // Entry contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_idx] <= Din;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC and LR registers with source muxes, incrementer, RAS and bus drive.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int RAS_DEPTH    = DEF_RAS_DEPTH,
  parameter int RESET_VECTOR = DEF_RESET_VECTOR,
  parameter int INC_STEP     = DEF_INC_STEP
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [2:0]       PcSel,
  input  logic             PcWe,
  input  logic             PcEn,
  input  logic             LrSel,
  input  logic             LrWe,
  input  logic             LrEn,
  input  logic             Call,
  input  logic             Ret,
  input  logic             Stall,
  input  logic             FlagClr,
  input  logic [WIDTH-1:0] AluIn,
  input  logic [WIDTH-1:0] SysBusIn,
  output logic [WIDTH-1:0] SysBusOut,
  output logic             SysBusOe,
  output logic [WIDTH-1:0] Pc,
  output logic             RasFull,
  output logic             RasEmpty,
  output logic             RasOvf,
  output logic             RasUnf
);

  logic [WIDTH-1:0] lr, pc_inc, pc_next, lr_next, ras_top, ras_sel;

  assign pc_inc = Pc + WIDTH'(INC_STEP);

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .Clock   (Clock),
    .Reset   (Reset),
    .Push    (Call & ~Stall),
    .Pop     (Ret & ~Stall),
    .Din     (pc_inc),
    .Top     (ras_top),
    .Full    (RasFull),
    .Empty   (RasEmpty),
    .Ovf     (RasOvf),
    .Unf     (RasUnf),
    .FlagClr (FlagClr)
  );

  // An underflowing return falls back to the link register.
  assign ras_sel = RasEmpty ? lr : ras_top;

  always_comb begin
    pc_next = Pc;
    case (PcSel)
      PcInc:    pc_next = pc_inc;
      PcSysbus: pc_next = SysBusIn;
      PcAluOut: pc_next = AluIn;
      PcLr:     pc_next = lr;
      PcRas:    pc_next = ras_sel;
      default:  pc_next = Pc;
    endcase
  end

  assign lr_next = (LrSel == LrPc) ? pc_inc : SysBusIn;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Pc <= WIDTH'(RESET_VECTOR);
      lr <= '0;
    end else if (!Stall) begin
      if (PcWe) Pc <= pc_next;
      if (LrWe) lr <= lr_next;
    end
  end

  assign SysBusOe  = PcEn | LrEn;
  assign SysBusOut = PcEn ? Pc : (LrEn ? lr : '0);

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with a queue of expected PC values scored after each clock edge.
module tb_pc_unit;
  import pc_unit_pkg::*;

  localparam int W = 16;

  logic         Clock = 1'b0;
  logic         Reset;
  logic [2:0]   PcSel;
  logic         PcWe, PcEn, LrSel, LrWe, LrEn, Call, Ret, Stall, FlagClr;
  logic [W-1:0] AluIn, SysBusIn, SysBusOut, Pc;
  logic         SysBusOe, RasFull, RasEmpty, RasOvf, RasUnf;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q [$];
  string        tag_q [$];

  pc_unit #(
    .WIDTH (W), .RAS_DEPTH (4), .RESET_VECTOR (0), .INC_STEP (1)
  ) dut (
    .Clock (Clock), .Reset (Reset), .PcSel (PcSel), .PcWe (PcWe), .PcEn (PcEn),
    .LrSel (LrSel), .LrWe (LrWe), .LrEn (LrEn), .Call (Call), .Ret (Ret),
    .Stall (Stall), .FlagClr (FlagClr), .AluIn (AluIn), .SysBusIn (SysBusIn),
    .SysBusOut (SysBusOut), .SysBusOe (SysBusOe), .Pc (Pc), .RasFull (RasFull),
    .RasEmpty (RasEmpty), .RasOvf (RasOvf), .RasUnf (RasUnf)
  );

  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_pc(input string tag, input logic [W-1:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic clk_and_score();
    @(posedge Clock);
    #1;
    while (exp_q.size() > 0) check(tag_q.pop_front(), Pc, exp_q.pop_front());
  endtask

  task automatic idle();
    PcWe = 0; LrWe = 0; Call = 0; Ret = 0; Stall = 0; FlagClr = 0;
    PcEn = 0; LrEn = 0;
  endtask

  initial begin
    Reset = 1; PcSel = PcInc; LrSel = LrSys; AluIn = '0; SysBusIn = '0;
    idle();
    #12;
    check("reset_pc", Pc, 16'h0000);
    check("reset_empty", RasEmpty, 1);
    check("reset_flags", {RasOvf, RasUnf}, 0);
    @(posedge Clock); #1;
    Reset = 0;

    // Test 1: bus drive and increment
    PcEn = 1; #1;
    check("bus_pc0", SysBusOut, 16'h0000);
    check("bus_oe", SysBusOe, 1);
    PcSel = PcInc; PcWe = 1;
    expect_pc("inc1", 16'd1); clk_and_score();
    expect_pc("inc2", 16'd2); clk_and_score();
    expect_pc("inc3", 16'd3); clk_and_score();
    check("bus_pc3", SysBusOut, 16'd3);
    PcEn = 0; #1;
    check("bus_off_oe", SysBusOe, 0);
    check("bus_off_data", SysBusOut, 16'h0000);

    // Test 2: wrap-around
    PcSel = PcSysbus; SysBusIn = 16'hFFFF;
    expect_pc("load_ffff", 16'hFFFF); clk_and_score();
    PcSel = PcInc;
    expect_pc("wrap", 16'h0000); clk_and_score();

    // Test 3: ALU, LR and undefined select
    PcSel = PcAluOut; AluIn = 16'h1234;
    expect_pc("alu", 16'h1234); clk_and_score();
    PcWe = 0; LrSel = LrPc; LrWe = 1;
    expect_pc("lr_hold_pc", 16'h1234); clk_and_score();
    LrWe = 0; LrEn = 1; #1;
    check("lr_on_bus", SysBusOut, 16'h1235);
    PcEn = 1; #1;
    check("bus_priority", SysBusOut, 16'h1234);
    PcEn = 0; LrEn = 0;
    PcSel = PcLr; PcWe = 1;
    expect_pc("from_lr", 16'h1235); clk_and_score();
    PcSel = 3'd7;
    expect_pc("undef_sel", 16'h1235); clk_and_score();

    // Test 4: nested calls and returns
    PcSel = PcSysbus; SysBusIn = 16'd10;
    expect_pc("pc10", 16'd10); clk_and_score();
    Call = 1; SysBusIn = 16'd20;
    expect_pc("pc20", 16'd20); clk_and_score();
    SysBusIn = 16'd30;
    expect_pc("pc30", 16'd30); clk_and_score();
    PcWe = 0;
    expect_pc("call3_hold", 16'd30); clk_and_score();
    check("call3_not_empty", RasEmpty, 0);
    Call = 0; PcSel = PcRas; PcWe = 1; Ret = 1;
    expect_pc("ret31", 16'd31); clk_and_score();
    expect_pc("ret21", 16'd21); clk_and_score();
    expect_pc("ret11", 16'd11); clk_and_score();
    check("ret_empty", RasEmpty, 1);
    check("ret_ovf", RasOvf, 0);
    check("ret_unf", RasUnf, 0);

    // Test 5: overflow then underflow with LR fallback
    Ret = 0; PcSel = PcSysbus; SysBusIn = 16'd100;
    expect_pc("pc100", 16'd100); clk_and_score();
    Call = 1;
    for (int k = 1; k <= 5; k++) begin
      SysBusIn = 16'(100 + 10 * k);
      expect_pc("call_seq", 16'(100 + 10 * k)); clk_and_score();
    end
    check("ovf_full", RasFull, 1);
    check("ovf_flag", RasOvf, 1);
    Call = 0; PcWe = 0; LrSel = LrSys; LrWe = 1; SysBusIn = 16'hBEEF;
    expect_pc("lr_load_hold", 16'd150); clk_and_score();
    LrWe = 0; PcSel = PcRas; PcWe = 1; Ret = 1;
    expect_pc("pop141", 16'd141); clk_and_score();
    expect_pc("pop131", 16'd131); clk_and_score();
    expect_pc("pop121", 16'd121); clk_and_score();
    expect_pc("pop111", 16'd111); clk_and_score();
    check("pop4_empty", RasEmpty, 1);
    check("pop4_unf", RasUnf, 0);
    expect_pc("pop_lr_fallback", 16'hBEEF); clk_and_score();
    check("unf_flag", RasUnf, 1);
    Ret = 0; PcWe = 0; FlagClr = 1;
    clk_and_score();
    check("clr_ovf", RasOvf, 0);
    check("clr_unf", RasUnf, 0);
    FlagClr = 0;

    // Test 6: stall and asynchronous reset
    Stall = 1; PcSel = PcInc; PcWe = 1; Call = 1;
    expect_pc("stall_pc", 16'hBEEF); clk_and_score();
    check("stall_empty", RasEmpty, 1);
    Stall = 0;
    expect_pc("call_after_stall", 16'hBEF0); clk_and_score();
    check("pre_reset_not_empty", RasEmpty, 0);
    idle();
    #2 Reset = 1;
    #1;
    check("async_reset_pc", Pc, 16'h0000);
    check("async_reset_empty", RasEmpty, 1);
    Reset = 0;
    expect_pc("post_reset_hold", 16'h0000); clk_and_score();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
